// File: rtl/priority_arbiter_rr.sv
// priority_arbiter_rr: registered N-way arbiter, fixed or round-robin, held grants.
// Ports: clk, rst_n, req[N], mode, ack -> gnt[N], gnt_idx[IDXW], gnt_valid.
module priority_arbiter_rr #(
  parameter int N    = 8,
  parameter int IDXW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  input  logic            mode,
  input  logic            ack,
  output logic [N-1:0]    gnt,
  output logic [IDXW-1:0] gnt_idx,
  output logic            gnt_valid
);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [IDXW-1:0] ptr_q, ptr_d;
  logic            vld_q, vld_d;

  logic [IDXW-1:0] base;
  logic [IDXW:0]   cand;
  logic [IDXW-1:0] win_idx;
  logic            win_vld;
  logic [N-1:0]    win_oh;

  // Search ptr-1, ptr-2, ... wrapping mod N; fixed mode is ptr = 0.
  always_comb begin
    base    = mode ? ptr_q : '0;
    cand    = '0;
    win_idx = '0;
    win_vld = 1'b0;
    for (int i = 1; i <= N; i++) begin
      cand = {1'b0, base} + (IDXW+1)'(N - i);
      if (cand >= (IDXW+1)'(N))
        cand = cand - (IDXW+1)'(N);
      if (!win_vld && req[cand[IDXW-1:0]]) begin
        win_vld = 1'b1;
        win_idx = cand[IDXW-1:0];
      end
    end
    win_oh = {{(N-1){1'b0}}, 1'b1} << win_idx;
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    vld_d   = vld_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d = GRANT;
          gnt_d   = win_oh;
          idx_d   = win_idx;
          vld_d   = 1'b1;
        end
      end
      GRANT: begin
        if (ack || !req[idx_q]) begin
          state_d = IDLE;
          gnt_d   = '0;
          idx_d   = '0;
          vld_d   = 1'b0;
          // Only a real release makes the owner lowest priority.
          if (ack && mode)
            ptr_d = idx_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      idx_q   <= '0;
      vld_q   <= 1'b0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      vld_q   <= vld_d;
      ptr_q   <= ptr_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = idx_q;
  assign gnt_valid = vld_q;

endmodule

// File: tb/tb_priority_arbiter_rr.sv
// tb_priority_arbiter_rr: arbiters at N = 8, 2, 5, 16 vs a behavioural model.
// Directed fixed/rr/hold/abort/reset cases on N = 8, then random traffic.
module tb_priority_arbiter_rr;

  localparam int NI = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int nn [NI] = '{8, 2, 5, 16};

  logic [15:0] req_v  [NI];
  logic        mode_v [NI];
  logic        ack_v  [NI];

  logic [7:0]  g0; logic [2:0] x0; logic v0;
  logic [1:0]  g1; logic [0:0] x1; logic v1;
  logic [4:0]  g2; logic [2:0] x2; logic v2;
  logic [15:0] g3; logic [3:0] x3; logic v3;

  priority_arbiter_rr #(.N(8)) u_n8 (
    .clk(clk), .rst_n(rst_n), .req(req_v[0][7:0]),
    .mode(mode_v[0]), .ack(ack_v[0]),
    .gnt(g0), .gnt_idx(x0), .gnt_valid(v0));

  priority_arbiter_rr #(.N(2)) u_n2 (
    .clk(clk), .rst_n(rst_n), .req(req_v[1][1:0]),
    .mode(mode_v[1]), .ack(ack_v[1]),
    .gnt(g1), .gnt_idx(x1), .gnt_valid(v1));

  priority_arbiter_rr #(.N(5)) u_n5 (
    .clk(clk), .rst_n(rst_n), .req(req_v[2][4:0]),
    .mode(mode_v[2]), .ack(ack_v[2]),
    .gnt(g2), .gnt_idx(x2), .gnt_valid(v2));

  priority_arbiter_rr #(.N(16)) u_n16 (
    .clk(clk), .rst_n(rst_n), .req(req_v[3]),
    .mode(mode_v[3]), .ack(ack_v[3]),
    .gnt(g3), .gnt_idx(x3), .gnt_valid(v3));

  int n_chk = 0;
  int n_bad = 0;

  // model: current owner (-1 = none) and last served requester
  int hold [NI];
  int ptr  [NI];

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] gnt_of(int j);
    case (j)
      0: return 16'(g0);
      1: return 16'(g1);
      2: return 16'(g2);
      default: return g3;
    endcase
  endfunction

  function automatic logic [31:0] idx_of(int j);
    case (j)
      0: return 32'(x0);
      1: return 32'(x1);
      2: return 32'(x2);
      default: return 32'(x3);
    endcase
  endfunction

  function automatic logic vld_of(int j);
    case (j)
      0: return v0;
      1: return v1;
      2: return v2;
      default: return v3;
    endcase
  endfunction

  function automatic int mask_of(int j);
    return (1 << nn[j]) - 1;
  endfunction

  function automatic int pick(int j);
    int n = nn[j];
    if (!mode_v[j]) begin
      for (int k = n - 1; k >= 0; k--)
        if (req_v[j][k]) return k;
    end else begin
      for (int k = 1; k <= n; k++) begin
        int c = (((ptr[j] - k) % n) + n) % n;
        if (req_v[j][c]) return c;
      end
    end
    return -1;
  endfunction

  task automatic model_edge();
    for (int j = 0; j < NI; j++) begin
      if (hold[j] < 0) begin
        hold[j] = pick(j);
      end else if (ack_v[j]) begin
        if (mode_v[j]) ptr[j] = hold[j];
        hold[j] = -1;
      end else if (!req_v[j][hold[j]]) begin
        hold[j] = -1;
      end
    end
  endtask

  task automatic model_reset();
    for (int j = 0; j < NI; j++) begin
      hold[j] = -1;
      ptr[j]  = 0;
    end
  endtask

  task automatic check_all(string tag);
    for (int j = 0; j < NI; j++) begin
      string t = $sformatf("%s_n%0d", tag, nn[j]);
      logic [31:0] eg = (hold[j] >= 0) ? (32'd1 << hold[j]) : 32'd0;
      logic [31:0] ei = (hold[j] >= 0) ? 32'(hold[j]) : 32'd0;
      chk({t, "_gnt"}, 32'(gnt_of(j)), eg);
      chk({t, "_idx"}, idx_of(j), ei);
      chk({t, "_vld"}, 32'(vld_of(j)), 32'(hold[j] >= 0));
      chk({t, "_oh"}, 32'($onehot0(gnt_of(j))), 32'd1);
    end
  endtask

  task automatic rand_inst(int j);
    logic [15:0] r;
    r = 16'($urandom) & 16'(mask_of(j));
    if ($urandom_range(0, 7) == 0) r = '0;
    if (hold[j] >= 0 && $urandom_range(0, 3) != 0) r[hold[j]] = 1'b1;
    req_v[j]  = r;
    mode_v[j] = 1'($urandom_range(0, 1));
    ack_v[j]  = ($urandom_range(0, 2) == 0);
  endtask

  task automatic set0(logic [7:0] r, logic m, logic a);
    req_v[0]  = {8'h00, r};
    mode_v[0] = m;
    ack_v[0]  = a;
    for (int j = 1; j < NI; j++) rand_inst(j);
  endtask

  task automatic tick(string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    int e_idx;
    for (int j = 0; j < NI; j++) begin
      req_v[j] = '0; mode_v[j] = 1'b0; ack_v[j] = 1'b0;
    end
    model_reset();
    #1;
    check_all("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // round-robin fairness, every requester asking, ack on every grant
    for (int e = 1; e <= 34; e++) begin
      for (int j = 0; j < NI; j++) begin
        req_v[j]  = 16'(mask_of(j));
        mode_v[j] = 1'b1;
        ack_v[j]  = (hold[j] >= 0);
      end
      tick("rr");
      if (e % 2 == 1) begin
        e_idx = (((7 - (e - 1) / 2) % 8) + 8) % 8;
        chk("rr_seq_idx", 32'(x0), 32'(e_idx));
      end
      chk("rr_seq_vld", 32'(v0), 32'(e % 2));
    end

    // fixed priority
    set0(8'hA5, 1'b0, 1'b0); tick("fix_a5");
    chk("fix_a5_g", 32'(g0), 32'h80);
    chk("fix_a5_i", 32'(x0), 32'd7);
    set0(8'hA5, 1'b0, 1'b1); tick("fix_rel");
    set0(8'h25, 1'b0, 1'b0); tick("fix_25");
    chk("fix_25_g", 32'(g0), 32'h20);
    chk("fix_25_i", 32'(x0), 32'd5);
    set0(8'h25, 1'b0, 1'b1); tick("fix_rel2");
    set0(8'h00, 1'b0, 1'b0); tick("fix_none");
    chk("fix_none_v", 32'(v0), 32'd0);
    set0(8'h00, 1'b0, 1'b1); tick("ack_idle");
    chk("ack_idle_v", 32'(v0), 32'd0);

    // hold while others toggle and mode flips, then abort
    set0(8'h08, 1'b0, 1'b0); tick("hold_g");
    for (int k = 0; k < 6; k++) begin
      set0(8'($urandom) | 8'h08, 1'($urandom_range(0, 1)), 1'b0);
      tick("hold");
      chk("hold_g08", 32'(g0), 32'h08);
    end
    set0(8'hF7, 1'b1, 1'b0); tick("abort");
    chk("abort_v", 32'(v0), 32'd0);
    // pointer still 7 from fairness: next rr winner is 6
    set0(8'hFF, 1'b1, 1'b0); tick("post_abort");
    chk("post_abort_g", 32'(g0), 32'h40);
    // ack with owner withdrawing counts as release
    set0(8'hBF, 1'b1, 1'b1); tick("ack_drop");
    chk("ack_drop_v", 32'(v0), 32'd0);
    set0(8'hFF, 1'b1, 1'b0); tick("after_ack_drop");
    chk("after_ack_drop_g", 32'(g0), 32'h20);
    set0(8'hFF, 1'b1, 1'b1); tick("rel3");

    // asynchronous reset mid-grant
    set0(8'h20, 1'b0, 1'b0); tick("pre_rst");
    chk("pre_rst_g", 32'(g0), 32'h20);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_g", 32'(g0), 32'h0);
    chk("arst_i", 32'(x0), 32'h0);
    chk("arst_v", 32'(v0), 32'h0);
    check_all("arst");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    set0(8'h01, 1'b0, 1'b0); tick("post_rst");
    chk("post_rst_g", 32'(g0), 32'h01);

    // random traffic on all sizes
    for (int k = 0; k < 400; k++) begin
      for (int j = 0; j < NI; j++) rand_inst(j);
      tick("rnd");
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/priority_arbiter_rr.md
# priority_arbiter_rr

Parametrised, registered successor to the combinational 8-bit priority-to-one-hot checker. It arbitrates N request lines and produces a registered one-hot grant, an encoded grant index and a valid flag. Fixed-priority mode (highest index wins) and round-robin mode are selectable. A grant is held until the owner acknowledges it or withdraws its request. It sits in front of the decoder block, where it replaces the one-hot priority stage wherever a shared resource needs fair, held grants.

## Interface
- N, default 8: number of requesters, N >= 2.
- IDXW, default $clog2(N): width of the encoded index (derived, not overridden).

- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  N  request lines; bit i = requester i.
- mode  in  1  0 = fixed priority (index N-1 highest), 1 = round-robin.
- ack  in  1  owner has finished with the grant; meaningful only while gnt_valid = 1.
- gnt  out  N  registered one-hot grant; all-zero when no grant is held.
- gnt_idx  out  IDXW  binary index of the granted bit; 0 when gnt_valid = 0.
- gnt_valid  out  1  high exactly when gnt is non-zero.

## Operation
- Two states: IDLE and GRANT. Reset state is IDLE.
- Reset values: gnt = 0, gnt_idx = 0, gnt_valid = 0, rr_ptr = 0.
- IDLE:
  - if req != 0, pick a winner k, load gnt = 1<<k, gnt_idx = k, gnt_valid = 1, and go to GRANT;
  - otherwise stay in IDLE with outputs 0.
- Winner selection, evaluated only in IDLE:
  - mode = 0: the highest set index of req wins.
  - mode = 1: the search order is rr_ptr-1, rr_ptr-2, …, 0, N-1, …, rr_ptr, taken mod N. The first set bit wins.
  - With rr_ptr = 0, round-robin order equals fixed order.
- GRANT, in decreasing precedence:
  - ack = 1: release. Go to IDLE and clear all outputs. In mode 1 only, rr_ptr <= gnt_idx, so the served requester becomes lowest priority.
  - req[gnt_idx] = 0 with ack = 0: abort. Go to IDLE, clear outputs, rr_ptr unchanged.
  - otherwise hold: outputs unchanged, regardless of other req bits or mode.
- mode is sampled only in IDLE. A mode change during GRANT takes effect at the next arbitration.
- rr_ptr is held in mode 0. When mode returns to 1, arbitration resumes from the stored pointer.
- ack while in IDLE is ignored.
- ack and withdrawal of req[gnt_idx] in the same cycle count as a release, so rr_ptr updates.
- Asserting rst_n low in any state clears all state and outputs immediately, without waiting for a clock edge.
- gnt is always zero or exactly one-hot. gnt_idx always matches gnt.

## Timing
- Grant latency: req seen at rising edge t in IDLE → gnt/gnt_idx/gnt_valid valid after edge t, i.e. visible during cycle t+1.
- Release: ack high at edge t during GRANT → outputs 0 during cycle t+1. That cycle is IDLE, and the next grant appears at t+2 at the earliest.
- The minimum spacing between consecutive grants is therefore 2 cycles: one GRANT cycle plus one mandatory IDLE bubble. There are no back-to-back grants.
- Abort has the same timing as release.
- All outputs are driven directly from registers, with no combinational path from req, mode or ack to any output.
- Reset release: the first arbitration happens at the first rising edge where rst_n = 1.

## Test plan
- Reset: drive rst_n = 0 mid-GRANT with gnt = 8'h20 → gnt, gnt_idx and gnt_valid go to 0 asynchronously. After release, req = 8'h01 → gnt = 8'h01 one cycle later.
- Fixed priority, N = 8, mode = 0:
  - req = 8'hA5 → gnt = 8'h80, gnt_idx = 7.
  - ack, then req = 8'h25 → gnt = 8'h20, gnt_idx = 5.
  - req = 0 → gnt_valid stays 0.
- Round-robin fairness, mode = 1, req held at 8'hFF, ack pulsed on every grant → grant sequence is indices 7, 6, 5, …, 0, 7, with a single IDLE cycle between grants.
- Hold and abort:
  - granted index 3 with ack = 0, while other req bits toggle and mode flips → gnt stays 8'h08.
  - then drop req[3] → gnt = 0 next cycle, and rr_ptr is unchanged (the next grant with req = 8'hFF in mode 1 is the same as before the abort).
- Simultaneous events:
  - ack together with req[gnt_idx] falling → treated as release, rr_ptr updated.
  - ack in IDLE → no effect.
- Parameter sweep: repeat the fairness test at N = 2, 5 and 16 → one-hot property and wrap-around from index 0 to N-1 hold, and gnt_idx always matches gnt.
